// File: rtl/bin_mac_pkg.sv
// Shared definitions for the sequential binary-input neuron MAC.
//   state_e   : controller states
//   DEF_W     : default operand / result width
//   DEF_SAT   : default symmetric clamp magnitude
//   params_ok : elaboration-time legality check of the parameter set
package bin_mac_pkg;

    typedef enum logic [1:0] {IDLE, ACC, BIAS, DONE} state_e;

    localparam int unsigned DEF_W   = 10;
    localparam int unsigned DEF_SAT = 255;

    // SAT must be representable as a positive W-bit value; LANES must split N_IN evenly.
    function automatic bit params_ok(int unsigned n_in, int unsigned w, int unsigned sat,
                                     int unsigned lanes);
        bit ok;
        ok = 1'b1;
        if (lanes == 0 || n_in == 0) ok = 1'b0;
        else if ((n_in % lanes) != 0) ok = 1'b0;
        if (w < 2 || w > 31) ok = 1'b0;
        else if (sat > ((32'd1 << (w - 1)) - 32'd1)) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bin_mac_seq_sat_add.sv
// Combinational W-bit signed add with symmetric clamp to [-SAT, +SAT].
//   i_a, i_b : signed operands
//   o_sum    : clamped sum
//   o_sat    : high when the clamp changed the result
module sat_add
    import bin_mac_pkg::*;
#(
    parameter int unsigned W   = DEF_W,
    parameter int unsigned SAT = DEF_SAT
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_sat
);

    logic signed [W:0] w_ext;
    logic signed [W:0] w_pos;
    logic signed [W:0] w_neg;

    // One extra bit so the raw sum cannot wrap before the comparison.
    assign w_ext = $signed({i_a[W-1], i_a}) + $signed({i_b[W-1], i_b});
    assign w_pos = (W+1)'(SAT);
    assign w_neg = -w_pos;

    always_comb begin
        o_sum = w_ext[W-1:0];
        o_sat = 1'b0;
        if (w_ext > w_pos) begin
            o_sum = w_pos[W-1:0];
            o_sat = 1'b1;
        end else if (w_ext < w_neg) begin
            o_sum = w_neg[W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/bin_mac_seq.sv
// Sequential binary-input neuron MAC.
//   clk, reset                : clock and synchronous active-high reset
//   start_valid / start_ready : operand handshake (ready only while idle)
//   in_bits, ws, bias, relu_en: activation bits, packed signed weights, bias, ReLU enable
//   out_valid / out_ready     : result handshake
//   mac_out, sat_flag         : signed result and sticky clamp indication
//   busy                      : operation in progress
module bin_mac_seq
    import bin_mac_pkg::*;
#(
    parameter int unsigned N_IN  = 16,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned SAT   = DEF_SAT,
    parameter int unsigned LANES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [N_IN-1:0]   in_bits,
    input  logic [N_IN*W-1:0] ws,
    input  logic [W-1:0]      bias,
    input  logic              relu_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      mac_out,
    output logic              sat_flag,
    output logic              busy
);

    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

    if (!params_ok(N_IN, W, SAT, LANES)) begin : g_bad_params
        $error("bin_mac_seq: illegal N_IN/W/SAT/LANES combination");
    end

    state_e              r_state, w_state_next;
    logic [N_IN-1:0]     r_bits;
    logic [N_IN*W-1:0]   r_ws;
    logic [W-1:0]        r_bias;
    logic                r_relu;
    logic [W-1:0]        r_acc;
    logic [IDX_W-1:0]    r_idx;
    logic [W-1:0]        r_mac;
    logic                r_sat;

    logic [W-1:0]        w_chain [LANES+1];
    logic [LANES-1:0]    w_lane_sat;
    logic [W-1:0]        w_bias_sum;
    logic                w_bias_sat;
    logic [W-1:0]        w_bias_res;

    // Lane 0 handles the highest index; each lane clamps before feeding the next,
    // so saturation order matches a strictly sequential MSB-first walk.
    assign w_chain[0] = r_acc;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] w_lidx;
        logic [W-1:0]     w_wt;
        logic [W-1:0]     w_sum;
        logic             w_sat;

        assign w_lidx = r_idx - IDX_W'(l);
        assign w_wt   = r_ws[int'(w_lidx)*W +: W];

        sat_add #(.W(W), .SAT(SAT)) u_add (
            .i_a   (w_chain[l]),
            .i_b   (w_wt),
            .o_sum (w_sum),
            .o_sat (w_sat)
        );

        assign w_chain[l+1]  = r_bits[w_lidx] ? w_sum : w_chain[l];
        assign w_lane_sat[l] = r_bits[w_lidx] & w_sat;
    end

    sat_add #(.W(W), .SAT(SAT)) u_bias_add (
        .i_a   (r_acc),
        .i_b   (r_bias),
        .o_sum (w_bias_sum),
        .o_sat (w_bias_sat)
    );

    // ReLU zeroing is not a clamp event and leaves sat_flag alone.
    assign w_bias_res = (r_relu && w_bias_sum[W-1]) ? '0 : w_bias_sum;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_next = ACC;
            ACC:     if (r_idx == IDX_LAST) w_state_next = BIAS;
            BIAS:    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        start_ready = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bits <= '0;
            r_ws   <= '0;
            r_bias <= '0;
            r_relu <= 1'b0;
            r_acc  <= '0;
            r_idx  <= IDX_INIT;
            r_mac  <= '0;
            r_sat  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_bits <= in_bits;
                        r_ws   <= ws;
                        r_bias <= bias;
                        r_relu <= relu_en;
                        r_acc  <= '0;
                        r_idx  <= IDX_INIT;
                        r_sat  <= 1'b0;
                    end
                end
                ACC: begin
                    r_acc <= w_chain[LANES];
                    r_sat <= r_sat | (|w_lane_sat);
                    r_idx <= r_idx - IDX_W'(LANES);
                end
                BIAS: begin
                    r_mac <= w_bias_res;
                    r_sat <= r_sat | w_bias_sat;
                end
                default: ;
            endcase
        end
    end

    assign mac_out  = r_mac;
    assign sat_flag = r_sat;

endmodule

// File: tb/tb_bin_mac_seq.sv
// Directed bench for bin_mac_seq: a LANES=1 and a LANES=4 instance share stimulus and are
// checked every cycle against a transaction-level model, plus literal expectations per op.
module tb_bin_mac_seq;

    localparam int N_IN = 16;
    localparam int W    = 10;
    localparam int SAT  = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_valid;
    logic [N_IN-1:0]   in_bits;
    logic [N_IN*W-1:0] ws;
    logic [W-1:0]      bias;
    logic              relu_en;
    logic              out_ready;

    logic              sr [2];
    logic              ov [2];
    logic              bz [2];
    logic              sf [2];
    logic [W-1:0]      mo [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bin_mac_seq #(.N_IN(N_IN), .W(W), .SAT(SAT), .LANES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr[0]),
        .in_bits(in_bits), .ws(ws), .bias(bias), .relu_en(relu_en),
        .out_valid(ov[0]), .out_ready(out_ready), .mac_out(mo[0]), .sat_flag(sf[0]),
        .busy(bz[0])
    );

    bin_mac_seq #(.N_IN(N_IN), .W(W), .SAT(SAT), .LANES(4)) u_dut4 (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr[1]),
        .in_bits(in_bits), .ws(ws), .bias(bias), .relu_en(relu_en),
        .out_valid(ov[1]), .out_ready(out_ready), .mac_out(mo[1]), .sat_flag(sf[1]),
        .busy(bz[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: walk indices MSB first, clamp after every add, then bias, then ReLU.
    function automatic void model_mac(output int res, output bit sat);
        int acc;
        int w;
        logic [W-1:0] wv;
        acc = 0;
        sat = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                wv  = ws[i*W +: W];
                w   = int'($signed(wv));
                acc = acc + w;
                if (acc > SAT) begin acc = SAT; sat = 1'b1; end
                else if (acc < -SAT) begin acc = -SAT; sat = 1'b1; end
            end
        end
        acc = acc + int'($signed(bias));
        if (acc > SAT) begin acc = SAT; sat = 1'b1; end
        else if (acc < -SAT) begin acc = -SAT; sat = 1'b1; end
        if (relu_en && acc < 0) acc = 0;
        res = acc;
    endfunction

    // Model: phase 0 waiting for operands, 1 computing, 2 holding a result.
    int    m_phase [2] = '{0, 0};
    int    m_cnt   [2] = '{0, 0};
    int    m_mac   [2] = '{0, 0};
    int    m_pmac  [2] = '{0, 0};
    bit    m_sat   [2] = '{1'b0, 1'b0};
    bit    m_psat  [2] = '{1'b0, 1'b0};
    int    lat_cfg [2] = '{N_IN + 1, N_IN / 4 + 1};
    string dn      [2] = '{"l1", "l4"};

    always @(posedge clk) begin
        int r;
        bit s;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_phase[d] = 0;
                m_mac[d]   = 0;
                m_sat[d]   = 1'b0;
            end else begin
                case (m_phase[d])
                    0: if (start_valid) begin
                        model_mac(r, s);
                        m_pmac[d]  = r;
                        m_psat[d]  = s;
                        m_sat[d]   = 1'b0;
                        m_cnt[d]   = lat_cfg[d];
                        m_phase[d] = 1;
                    end
                    1: begin
                        m_cnt[d]--;
                        if (m_cnt[d] == 0) begin
                            m_phase[d] = 2;
                            m_mac[d]   = m_pmac[d];
                            m_sat[d]   = m_psat[d];
                        end
                    end
                    default: if (out_ready) m_phase[d] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk({dn[d], " start_ready"}, int'(sr[d]), int'(m_phase[d] == 0));
            chk({dn[d], " out_valid"}, int'(ov[d]), int'(m_phase[d] == 2));
            chk({dn[d], " busy"}, int'(bz[d]), int'(m_phase[d] != 0));
            chk({dn[d], " mac_out"}, int'($signed(mo[d])), m_mac[d]);
            if (m_phase[d] != 1) chk({dn[d], " sat_flag"}, int'(sf[d]), int'(m_sat[d]));
        end
    end

    task automatic set_w(input int idx, input int val);
        ws[idx*W +: W] = val[W-1:0];
    endtask

    task automatic run_op(input string name, input int exp_res, input int exp_sat,
                          input int hold);
        int lat1;
        int lat4;
        lat1 = -1;
        lat4 = -1;
        @(negedge clk);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            if (ov[0] && lat1 < 0) lat1 = e;
            if (ov[1] && lat4 < 0) lat4 = e;
            if (lat1 >= 0 && lat4 >= 0) break;
            @(negedge clk);
        end
        chk({name, " latency l1"}, lat1, 17);
        chk({name, " latency l4"}, lat4, 5);
        for (int d = 0; d < 2; d++) begin
            chk({name, " ", dn[d], " result"}, int'($signed(mo[d])), exp_res);
            chk({name, " ", dn[d], " sat"}, int'(sf[d]), exp_sat);
        end
        repeat (hold) begin
            @(negedge clk);
            chk({name, " hold valid"}, int'(ov[0]), 1);
            chk({name, " hold result"}, int'($signed(mo[0])), exp_res);
            chk({name, " hold ready"}, int'(sr[0]), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk({name, " ", dn[d], " post ready"}, int'(sr[d]), 1);
            chk({name, " ", dn[d], " post valid"}, int'(ov[d]), 0);
            chk({name, " ", dn[d], " post result"}, int'($signed(mo[d])), exp_res);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = 1'b0;
        in_bits     = '0;
        ws          = '0;
        bias        = '0;
        relu_en     = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset start_ready", int'(sr[0]), 1);
        chk("reset out_valid", int'(ov[0]), 0);
        chk("reset mac_out", int'(mo[0]), 0);
        chk("reset sat_flag", int'(sf[0]), 0);
        chk("reset busy", int'(bz[0]), 0);
        reset = 1'b0;

        // All weights +20, all bits set: 320 clamps to 255.
        in_bits = 16'hFFFF;
        for (int i = 0; i < N_IN; i++) set_w(i, 20);
        run_op("s1", 255, 1, 0);

        // Single weight -7 plus bias 3, with and without ReLU.
        in_bits = 16'h0001;
        ws      = '0;
        set_w(0, -7);
        bias    = 10'd3;
        run_op("s2", -4, 0, 0);
        relu_en = 1'b1;
        run_op("s2 relu", 0, 0, 0);

        // Order-dependent clamp: 200, 255 (clamped), 155; also held under backpressure.
        relu_en = 1'b0;
        in_bits = 16'hE000;
        ws      = '0;
        set_w(15, 200);
        set_w(14, 100);
        set_w(13, -100);
        bias    = '0;
        run_op("s3", 155, 1, 5);

        // No bits set: result is clamp(bias).
        in_bits = '0;
        bias    = 10'h2D4;  // -300
        run_op("s3 bias", -255, 1, 0);

        // Abort with reset during the 8th accumulate cycle.
        in_bits = 16'hFFFF;
        for (int i = 0; i < N_IN; i++) set_w(i, 20);
        bias = '0;
        @(negedge clk);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk({"abort ", dn[d], " start_ready"}, int'(sr[d]), 1);
            chk({"abort ", dn[d], " out_valid"}, int'(ov[d]), 0);
            chk({"abort ", dn[d], " mac_out"}, int'(mo[d]), 0);
            chk({"abort ", dn[d], " sat_flag"}, int'(sf[d]), 0);
        end

        // A normal operation after the abort.
        in_bits = 16'h0001;
        ws      = '0;
        set_w(0, -7);
        bias    = 10'd3;
        run_op("s5", -4, 0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
